// File: rtl/wb_port_arbiter.sv
// Purpose : two-requester arbiter for the register-file write port, with an
//           optional post-reset clear sweep (macro WB_ARB_REGFILE_CLEAR_EN).
// Latency : grant is combinational; the register-file write appears 1 cycle
//           after the transfer.
// Backpressure: a requester without a grant holds req/rd/data until it is
//           granted. No grants are issued during reset or the clear sweep.
//
// Ports:
//   clk, reset          single clock, synchronous active-high reset
//   req0/rd0/data0/gnt0 requester 0 (ALU writeback)
//   req1/rd1/data1/gnt1 requester 1 (load writeback)
//   reg_write/Rd/write_data  registered register-file write port
//   busy                high while the clear sweep owns the write port
//
// Build option: define WB_ARB_REGFILE_CLEAR_EN to enter a CLEAR state after
// reset that writes zero to registers 0..NREGS-1 before arbitration starts.
// Without it, the block comes out of reset directly in RUN and busy is 0.
module wb_port_arbiter #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NREGS  = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0,
  input  logic [ADDR_W-1:0] rd0,
  input  logic [DATA_W-1:0] data0,
  output logic              gnt0,
  input  logic              req1,
  input  logic [ADDR_W-1:0] rd1,
  input  logic [DATA_W-1:0] data1,
  output logic              gnt1,
  output logic              reg_write,
  output logic [ADDR_W-1:0] Rd,
  output logic [DATA_W-1:0] write_data,
  output logic              busy
);

  // The sweep index is ADDR_W bits wide, so every register must be addressable.
  if (NREGS < 1 || NREGS > (1 << ADDR_W)) begin : g_bad_nregs
    $error("wb_port_arbiter: NREGS must be in 1..2**ADDR_W");
  end

  logic              clearing;   // clear sweep owns the write port this cycle
  logic [ADDR_W-1:0] clear_idx;  // register being zeroed this cycle

  // Last-grant pointer: 1 means requester 1 was granted last.
  logic              last_q, last_d;
  logic              reg_write_q, reg_write_d;
  logic [ADDR_W-1:0] rd_q, rd_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;

`ifdef WB_ARB_REGFILE_CLEAR_EN
  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NREGS - 1);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] sweep_q, sweep_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_CLEAR;
      sweep_q <= '0;
    end else begin
      state_q <= state_d;
      sweep_q <= sweep_d;
    end
  end

  // The last index is written in the same cycle we leave CLEAR, so the
  // first RUN grant lands right behind the final clear write. The index
  // holds at the last value rather than wrapping.
  always_comb begin
    state_d = state_q;
    sweep_d = sweep_q;
    if (state_q == ST_CLEAR) begin
      if (sweep_q == LAST_IDX) begin
        state_d = ST_RUN;
      end else begin
        sweep_d = sweep_q + 1'b1;
      end
    end
  end

  assign clearing  = (state_q == ST_CLEAR);
  assign clear_idx = sweep_q;
`else
  assign clearing  = 1'b0;
  assign clear_idx = '0;
`endif

  assign busy = clearing;

  // Grants. On a tie the requester that was not granted last wins:
  // last_q=1 (requester 1 last) hands the tie to requester 0.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (!reset && !clearing) begin
      if (req0 && req1) begin
        gnt0 = last_q;
        gnt1 = ~last_q;
      end else begin
        gnt0 = req0;
        gnt1 = req1;
      end
    end
  end

  // Next-cycle write port. A transfer to x0 is consumed (and moves the
  // pointer) but never raises reg_write, so x0 stays zero.
  always_comb begin
    last_d      = last_q;
    reg_write_d = 1'b0;
    rd_d        = rd_q;
    wdata_d     = wdata_q;
    if (clearing) begin
      reg_write_d = 1'b1;
      rd_d        = clear_idx;
      wdata_d     = '0;
    end else if (gnt0) begin
      reg_write_d = |rd0;
      rd_d        = rd0;
      wdata_d     = data0;
      last_d      = 1'b0;
    end else if (gnt1) begin
      reg_write_d = |rd1;
      rd_d        = rd1;
      wdata_d     = data1;
      last_d      = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      last_q      <= 1'b1;
      reg_write_q <= 1'b0;
      rd_q        <= '0;
      wdata_q     <= '0;
    end else begin
      last_q      <= last_d;
      reg_write_q <= reg_write_d;
      rd_q        <= rd_d;
      wdata_q     <= wdata_d;
    end
  end

  assign reg_write  = reg_write_q;
  assign Rd         = rd_q;
  assign write_data = wdata_q;

endmodule

// File: tb/tb_wb_port_arbiter.sv
module tb_wb_port_arbiter;

`ifdef WB_ARB_REGFILE_CLEAR_EN
  localparam bit CLR_EN = 1'b1;
`else
  localparam bit CLR_EN = 1'b0;
`endif
  localparam int NREGS = 32;

  logic        clk;
  logic        reset;
  logic        req0, req1;
  logic [4:0]  rd0, rd1;
  logic [31:0] data0, data1;
  logic        gnt0, gnt1;
  logic        reg_write;
  logic [4:0]  Rd;
  logic [31:0] write_data;
  logic        busy;

  int errors = 0;
  int checks = 0;

  wb_port_arbiter #(.DATA_W(32), .ADDR_W(5), .NREGS(NREGS)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .rd0(rd0), .data0(data0), .gnt0(gnt0),
    .req1(req1), .rd1(rd1), .data1(data1), .gnt1(gnt1),
    .reg_write(reg_write), .Rd(Rd), .write_data(write_data), .busy(busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------
  // Reference model: what the outputs must be this cycle, advanced once per
  // cycle from the inputs that the coming posedge will sample.
  // ---------------------------------------------------------------------
  bit          m_valid = 1'b0;  // a reset has been seen
  bit          m_clearing;      // sweep still owns the port
  int          m_idx;           // next register to zero
  bit          m_last1;         // requester 1 was granted last
  bit          m_rw;            // expected reg_write now
  bit          m_chk_data;      // Rd/write_data meaningful now
  logic [4:0]  m_rd;
  logic [31:0] m_wd;

  always @(negedge clk) begin : model
    bit e_g0, e_g1;
    e_g0 = 1'b0;
    e_g1 = 1'b0;
    if (m_valid) begin
      if (!reset && !m_clearing) begin
        if (req0 && req1) begin
          e_g0 = m_last1;      // the one not granted last wins
          e_g1 = !m_last1;
        end else begin
          e_g0 = req0;
          e_g1 = req1;
        end
      end
      check("model_gnt0", gnt0, e_g0);
      check("model_gnt1", gnt1, e_g1);
      check("gnt_exclusive", gnt0 & gnt1, 0);
      check("model_busy", busy, m_clearing);
      check("model_reg_write", reg_write, m_rw);
      if (m_chk_data) begin
        check("model_Rd", Rd, m_rd);
        check("model_write_data", write_data, m_wd);
      end
    end
    if (reset) begin
      m_valid    = 1'b1;
      m_rw       = 1'b0;
      m_rd       = '0;
      m_wd       = '0;
      m_chk_data = 1'b1;
      m_last1    = 1'b1;
      m_clearing = CLR_EN;
      m_idx      = 0;
    end else if (m_valid) begin
      if (m_clearing) begin
        m_rw       = 1'b1;
        m_rd       = 5'(m_idx);
        m_wd       = '0;
        m_chk_data = 1'b1;
        m_idx++;
        if (m_idx == NREGS) m_clearing = 1'b0;
      end else if (e_g0 || e_g1) begin
        m_rd       = e_g0 ? rd0 : rd1;
        m_wd       = e_g0 ? data0 : data1;
        m_rw       = (m_rd != 0);
        m_chk_data = m_rw;
        m_last1    = e_g1;
      end else begin
        m_rw       = 1'b0;
        m_chk_data = 1'b0;
      end
    end
  end

  // ---------------------------------------------------------------------
  // Directed scenarios with literal expectations
  // ---------------------------------------------------------------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_and_wait();
    bit done;
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    done = 1'b0;
    for (int i = 0; i < 100 && !done; i++) begin
      @(negedge clk);
      if (busy == 1'b0) done = 1'b1;
      else tick();
    end
    check("reset_wait_busy_low", done, 1);
  endtask

  initial begin
    int n_writes;
    bit g0, g1;
    bit found;
    logic exp_g0 [4];
    logic [4:0] exp_rd [4];
    exp_g0 = '{1'b1, 1'b0, 1'b1, 1'b0};
    exp_rd = '{5'd3, 5'd7, 5'd3, 5'd7};

    reset = 1'b1;
    req0 = 1'b0; rd0 = '0; data0 = '0;
    req1 = 1'b0; rd1 = '0; data1 = '0;

    // Reset values, and no grant while reset is held.
    tick();
    req0 = 1'b1; rd0 = 5'd1; data0 = 32'h11;
    @(negedge clk);
    check("reset_gnt0", gnt0, 0);
    check("reset_reg_write", reg_write, 0);
    check("reset_Rd", Rd, 0);
    check("reset_write_data", write_data, 0);
    tick();
    reset = 1'b0;
    req0 = 1'b0;

    // Scenario 1: idle after reset.
    @(negedge clk);
    check("s1_busy_after_reset", busy, CLR_EN);
    n_writes = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      @(negedge clk);
      if (reg_write) begin
        check("s1_clear_Rd", Rd, n_writes);
        check("s1_clear_data", write_data, 0);
        n_writes++;
      end
    end
    check("s1_write_count", n_writes, CLR_EN ? 32 : 0);
    check("s1_busy_end", busy, 0);

    // Scenario 2: single request.
    tick();
    req0 = 1'b1; rd0 = 5'd5; data0 = 32'h1234;
    @(negedge clk);
    check("s2_gnt0", gnt0, 1);
    check("s2_gnt1", gnt1, 0);
    tick();
    req0 = 1'b0;
    @(negedge clk);
    check("s2_reg_write", reg_write, 1);
    check("s2_Rd", Rd, 5);
    check("s2_write_data", write_data, 32'h1234);

    // Scenario 3: sustained tie after reset alternates 0,1,0,1.
    reset_and_wait();
    tick();
    req0 = 1'b1; rd0 = 5'd3; data0 = 32'hA0;
    req1 = 1'b1; rd1 = 5'd7; data1 = 32'hB1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (k < 4) begin
        check("s3_gnt0", gnt0, exp_g0[k]);
        check("s3_gnt1", gnt1, !exp_g0[k]);
      end
      if (k >= 1) begin
        check("s3_reg_write", reg_write, 1);
        check("s3_Rd", Rd, exp_rd[k-1]);
      end
      tick();
      if (k == 3) begin
        req0 = 1'b0;
        req1 = 1'b0;
      end
    end

    // Scenario 4: write to x0 is consumed and advances the pointer.
    req0 = 1'b1; rd0 = 5'd2; data0 = 32'h22;
    @(negedge clk);
    check("s4_pre_gnt0", gnt0, 1);
    tick();
    req0 = 1'b0;
    req1 = 1'b1; rd1 = 5'd0; data1 = 32'hFFFF;
    @(negedge clk);
    check("s4_gnt1", gnt1, 1);
    tick();
    req0 = 1'b1; rd0 = 5'd9; data0 = 32'h99;
    req1 = 1'b1; rd1 = 5'd10; data1 = 32'hAA;
    @(negedge clk);
    check("s4_x0_no_write", reg_write, 0);
    check("s4_tie_gnt0", gnt0, 1);
    tick();
    req0 = 1'b0;
    req1 = 1'b0;
    @(negedge clk);
    check("s4_tie_Rd", Rd, 9);
    check("s4_tie_reg_write", reg_write, 1);

`ifdef WB_ARB_REGFILE_CLEAR_EN
    // Scenario 5: reset mid-sweep restarts from Rd=0; requests wait for busy.
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    req0 = 1'b1; rd0 = 5'd4; data0 = 32'h55;
    found = 1'b0;
    for (int i = 0; i < 50 && !found; i++) begin
      @(negedge clk);
      if (reg_write && Rd == 5'd10) found = 1'b1;
      else tick();
    end
    check("s5_reached_rd10", found, 1);
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    @(negedge clk);
    check("s5_restart_busy", busy, 1);
    check("s5_restart_no_write", reg_write, 0);
    check("s5_restart_gnt0", gnt0, 0);
    for (int i = 0; i < NREGS; i++) begin
      tick();
      @(negedge clk);
      check("s5_sweep_write", {reg_write, Rd, write_data}, {1'b1, 5'(i), 32'h0});
      check("s5_gnt_after_busy", gnt0, i == NREGS - 1);
    end
    tick();
    req0 = 1'b0;
`else
    found = 1'b0;
`endif

    // Scenario 6: random traffic; requesters hold until granted.
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      g0 = gnt0;
      g1 = gnt1;
      tick();
      reset = ($urandom_range(0, 99) == 0);
      if (!(req0 && !g0)) begin
        req0  = ($urandom_range(0, 9) < 6);
        rd0   = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
        data0 = $urandom;
      end
      if (!(req1 && !g1)) begin
        req1  = ($urandom_range(0, 9) < 6);
        rd1   = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
        data1 = $urandom;
      end
    end
    reset = 1'b0;
    req0 = 1'b0;
    req1 = 1'b0;
    repeat (3) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/wb_port_arbiter.md
WB_PORT_ARBITER -- requirements
Module: wb_port_arbiter

Interface
REQ-001 Parameters SHALL be: DATA_W, 32, write data width; ADDR_W, 5, register index width; NREGS, 32, register count swept by the clear sequence.
REQ-002 Ports SHALL be, in order:
- clk  in  1  single clock; all state updates on posedge.
- reset  in  1  reset; synchronous, active-high.
- req0  in  1  requester 0 (ALU writeback) write request.
- rd0  in  ADDR_W  requester 0 destination index.
- data0  in  DATA_W  requester 0 write data.
- gnt0  out  1  requester 0 grant.
- req1  in  1  requester 1 (load writeback) write request.
- rd1  in  ADDR_W  requester 1 destination index.
- data1  in  DATA_W  requester 1 write data.
- gnt1  out  1  requester 1 grant.
- reg_write  out  1  register file write enable.
- Rd  out  ADDR_W  register file write index.
- write_data  out  DATA_W  register file write data.
- busy  out  1  high while the clear sequence owns the write port.

Function
REQ-003 A transfer on port n SHALL occur in a cycle where reqn and gntn are both 1.
REQ-004 gntn SHALL be combinational from reqn and internal state; gnt0 and gnt1 SHALL never both be 1.
REQ-005 A requester holding reqn=1 without a grant SHALL keep rdn and datan stable; the block does not check this.
REQ-006 In state RUN with exactly one request active, that request SHALL be granted in the same cycle.
REQ-007 In RUN with both requests active, the requester not granted last SHALL win. The 1-bit last-grant pointer SHALL update only on a transfer.
REQ-008 After reset the pointer SHALL equal 1, so req0 wins the first tie.
REQ-009 A transfer SHALL drive reg_write=1, Rd=rdn and write_data=datan on the following cycle (latency 1, registered outputs).
REQ-010 reg_write SHALL be 0 in any RUN cycle that follows a cycle with no transfer.
REQ-011 A transfer with rdn=0 SHALL be granted and consumed, and SHALL update the pointer. The following cycle SHALL show reg_write=0, so x0 stays 0.
REQ-012 Back-to-back transfers SHALL sustain one write per cycle. A requester losing a tie SHALL be granted no later than the next cycle if the other requester does not win again under REQ-007.
REQ-013 States SHALL be CLEAR and RUN: CLEAR -> RUN when the sweep index reaches NREGS-1; RUN -> CLEAR only on reset.
REQ-014 CLEAR behaviour, per cycle:
- gnt0=gnt1=0 and busy=1.
- Registered outputs on the next cycle: reg_write=1, Rd=sweep index, write_data=0.
- Index counts 0..NREGS-1, incrementing by 1 and never wrapping.
REQ-015 The last clear write (Rd=NREGS-1) and the first RUN-cycle grant SHALL be adjacent, with no idle cycle between them.

Reset
REQ-016 With reset=1 at a posedge, the next-cycle values SHALL be:
- reg_write=0, Rd=0, write_data=0.
- Pointer=1.
- Sweep index=0.
- State per REQ-019/REQ-020.
REQ-017 While reset=1, gnt0=gnt1=0.
REQ-018 Reset asserted mid-CLEAR or mid-transfer SHALL discard progress. The sweep restarts at index 0 and the pending registered write is dropped.

Configuration
REQ-019 With macro WB_ARB_REGFILE_CLEAR_EN defined:
- Reset enters CLEAR.
- The sweep zeroes all NREGS registers in NREGS cycles.
- busy=1 from reset until the cycle after the Rd=NREGS-1 write.
REQ-020 Without WB_ARB_REGFILE_CLEAR_EN:
- The CLEAR state and sweep counter SHALL be compiled out.
- Reset enters RUN directly and busy is tied 0.
- Requests are granted in the first cycle after reset deasserts.

Verification
REQ-021 Scenario 1: reset 1 cycle, then idle, macro on -> reg_write=1 for exactly 32 cycles, Rd 0..31 in order, write_data=0, busy falls after Rd=31; macro off -> reg_write=0 and busy=0.
REQ-022 Scenario 2: RUN, req0=1 rd0=5 data0=0x1234 for one cycle -> gnt0=1 same cycle; next cycle reg_write=1, Rd=5, write_data=0x1234.
REQ-023 Scenario 3: RUN after reset, req0 and req1 held for 4 cycles (rd0=3, rd1=7) -> grants 0,1,0,1; Rd sequence 3,7,3,7 one cycle later.
REQ-024 Scenario 4: req1=1 rd1=0 data1=0xFFFF -> gnt1=1; next cycle reg_write=0; pointer advances so the next tie grants requester 0.
REQ-025 Scenario 5: macro on, reset, then reset pulsed again when Rd=10 -> sweep restarts at Rd=0, 32 writes follow, and no grant occurs before busy falls.
REQ-026 Scenario 6: over all random stimulus, gnt0&gnt1 is never 1, and every cycle with reg_write=1 in RUN is preceded by exactly one transfer with a nonzero rd.
